// File: rtl/err_monitor.sv
// Windowed error monitor for an approximate adder: compares O against the exact A+B
// and reports the sum, maximum and nonzero count of |O - (A+B)| over 2^WIN_LOG2 samples.
module err_monitor #(
  parameter int WIN_LOG2 = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [15:0]              A,
  input  logic [15:0]              B,
  input  logic [16:0]              O,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [17+WIN_LOG2-1:0]   err_sum,
  output logic [16:0]              err_max,
  output logic [WIN_LOG2:0]        err_cnt
);

  typedef enum logic [0:0] {
    ST_ACC = 1'b0,
    ST_RPT = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic [WIN_LOG2-1:0]      cnt_q, cnt_d;
  logic                     full_q, full_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic                     s1_valid_q, s1_valid_d;
  logic                     s1_last_q, s1_last_d;
  logic [16:0]              s1_err_q, s1_err_d;
  logic [17+WIN_LOG2-1:0]   sum_q, sum_d;
  logic [16:0]              max_q, max_d;
  logic [WIN_LOG2:0]        ecnt_q, ecnt_d;

  logic                     accept_s;
  logic                     last_s;
  logic [16:0]              ref_s;
  logic [16:0]              abs_err_s;

  // Sample acceptance, exact reference and error magnitude (no wraparound when O < E).
  always_comb begin
    accept_s  = in_valid && in_ready_q;
    last_s    = accept_s && (cnt_q == {WIN_LOG2{1'b1}});
    ref_s     = {1'b0, A} + {1'b0, B};
    if (O >= ref_s) begin
      abs_err_s = O - ref_s;
    end else begin
      abs_err_s = ref_s - O;
    end
  end

  // Next-state: stage 1 capture, stage 2 accumulation, ACC/RPT control.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    full_d     = full_q;
    s1_valid_d = 1'b0;
    s1_last_d  = 1'b0;
    s1_err_d   = s1_err_q;
    sum_d      = sum_q;
    max_d      = max_q;
    ecnt_d     = ecnt_q;

    if (accept_s) begin
      cnt_d      = cnt_q + WIN_LOG2'(1);
      s1_valid_d = 1'b1;
      s1_last_d  = last_s;
      s1_err_d   = abs_err_s;
      full_d     = full_q | last_s;
    end else begin
      cnt_d      = cnt_q;
    end

    if (s1_valid_q) begin
      sum_d  = sum_q + (17+WIN_LOG2)'(s1_err_q);
      max_d  = (s1_err_q > max_q) ? s1_err_q : max_q;
      ecnt_d = ecnt_q + ((s1_err_q != 17'd0) ? (WIN_LOG2+1)'(1) : (WIN_LOG2+1)'(0));
    end else begin
      sum_d  = sum_q;
    end

    // The window closes on the same edge that folds in its last sample.
    case (state_q)
      ST_ACC: begin
        if (s1_valid_q && s1_last_q) begin
          state_d = ST_RPT;
        end else begin
          state_d = ST_ACC;
        end
      end
      ST_RPT: begin
        if (out_ready) begin
          state_d = ST_ACC;
          full_d  = 1'b0;
          cnt_d   = '0;
          sum_d   = '0;
          max_d   = 17'd0;
          ecnt_d  = '0;
        end else begin
          state_d = ST_RPT;
        end
      end
      default: begin
        state_d = ST_ACC;
      end
    endcase

    in_ready_d  = (state_d == ST_ACC) && !full_d;
    out_valid_d = (state_d == ST_RPT);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ACC;
      cnt_q       <= '0;
      full_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_err_q    <= 17'd0;
      sum_q       <= '0;
      max_q       <= 17'd0;
      ecnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      full_q      <= full_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_err_q    <= s1_err_d;
      sum_q       <= sum_d;
      max_q       <= max_d;
      ecnt_q      <= ecnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign err_sum   = sum_q;
  assign err_max   = max_q;
  assign err_cnt   = ecnt_q;

endmodule

// File: tb/tb_err_monitor.sv
// Directed bench for err_monitor: one instance with WIN_LOG2=1 and one with WIN_LOG2=2,
// sharing stimulus; sel picks which instance the checks observe.
module tb_err_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] a_s;
  logic [15:0] b_s;
  logic [16:0] o_s;

  logic        rdy1, ov1;
  logic [17:0] sum1;
  logic [16:0] max1;
  logic [1:0]  cnt1;
  logic        rdy2, ov2;
  logic [18:0] sum2;
  logic [16:0] max2;
  logic [2:0]  cnt2;

  logic        rdy_s, ov_s;
  logic [31:0] sum_s, max_s, cnt_s;
  int          sel;
  int          n_chk;
  int          n_pass;

  always #5 clk = ~clk;

  err_monitor #(.WIN_LOG2(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .A(a_s), .B(b_s), .O(o_s), .out_valid(ov1), .out_ready(out_ready),
    .err_sum(sum1), .err_max(max1), .err_cnt(cnt1)
  );

  err_monitor #(.WIN_LOG2(2)) u_w2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2),
    .A(a_s), .B(b_s), .O(o_s), .out_valid(ov2), .out_ready(out_ready),
    .err_sum(sum2), .err_max(max2), .err_cnt(cnt2)
  );

  always_comb begin
    if (sel == 1) begin
      rdy_s = rdy2;
      ov_s  = ov2;
      sum_s = 32'(sum2);
      max_s = 32'(max2);
      cnt_s = 32'(cnt2);
    end else begin
      rdy_s = rdy1;
      ov_s  = ov1;
      sum_s = 32'(sum1);
      max_s = 32'(max1);
      cnt_s = 32'(cnt1);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_s       = 16'd0;
    b_s       = 16'd0;
    o_s       = 17'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Presents one sample and returns just after the edge that accepts it.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [16:0] o);
    @(negedge clk);
    a_s      = a;
    b_s      = b;
    o_s      = o;
    in_valid = 1'b1;
    for (int k = 0; k < 50 && !rdy_s; k++) @(negedge clk);
    check("send_ready", 32'(rdy_s), 32'd1);
    @(posedge clk);
  endtask

  task automatic wait_report();
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 20 && !ov_s; k++) @(negedge clk);
    check("report_valid", 32'(ov_s), 32'd1);
  endtask

  task automatic handshake();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("hs_out_valid", 32'(ov_s), 32'd0);
    check("hs_in_ready", 32'(rdy_s), 32'd1);
    check("hs_sum", sum_s, 32'd0);
    check("hs_max", max_s, 32'd0);
    check("hs_cnt", cnt_s, 32'd0);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    sel    = 0;

    // Reset state and the two-sample window.
    apply_reset();
    check("rst_in_ready", 32'(rdy_s), 32'd1);
    check("rst_out_valid", 32'(ov_s), 32'd0);
    check("rst_sum", sum_s, 32'd0);
    check("rst_max", max_s, 32'd0);
    check("rst_cnt", cnt_s, 32'd0);
    send(16'd0, 16'd0, 17'd5);
    send(16'd3, 16'd4, 17'd7);
    @(negedge clk);
    in_valid = 1'b0;
    check("full_in_ready", 32'(rdy_s), 32'd0);
    wait_report();
    check("w1_sum", sum_s, 32'd5);
    check("w1_max", max_s, 32'd5);
    check("w1_cnt", cnt_s, 32'd1);

    // Consumer stalls for 10 cycles while upstream keeps offering samples.
    a_s      = 16'd1;
    b_s      = 16'd1;
    o_s      = 17'd100;
    in_valid = 1'b1;
    repeat (10) @(negedge clk);
    check("stall_out_valid", 32'(ov_s), 32'd1);
    check("stall_in_ready", 32'(rdy_s), 32'd0);
    check("stall_sum", sum_s, 32'd5);
    check("stall_max", max_s, 32'd5);
    check("stall_cnt", cnt_s, 32'd1);
    handshake();

    // O below the exact sum gives a magnitude, not a wrapped difference.
    send(16'd100, 16'd20, 17'd112);
    send(16'd1, 16'd1, 17'd2);
    wait_report();
    check("under_sum", sum_s, 32'd8);
    check("under_max", max_s, 32'd8);
    check("under_cnt", cnt_s, 32'd1);
    handshake();

    // Worst-case errors, four samples back-to-back.
    sel = 1;
    apply_reset();
    for (int i = 0; i < 4; i++) send(16'd65535, 16'd65535, 17'd0);
    wait_report();
    check("big_sum", sum_s, 32'd524280);
    check("big_max", max_s, 32'd131070);
    check("big_cnt", cnt_s, 32'd4);
    handshake();

    // in_valid toggled every other cycle, O = E + 1.
    for (int i = 0; i < 4; i++) begin
      send(16'(i * 10), 16'd7, 17'(i * 10 + 8));
      @(negedge clk);
      in_valid = 1'b0;
      if (i < 3) check("early_report", 32'(ov_s), 32'd0);
    end
    wait_report();
    check("gap_sum", sum_s, 32'd4);
    check("gap_max", max_s, 32'd1);
    check("gap_cnt", cnt_s, 32'd4);
    handshake();

    // Reset mid-window discards the partial statistics.
    sel = 0;
    apply_reset();
    send(16'd0, 16'd0, 17'd9);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("partial_sum", sum_s, 32'd9);
    check("partial_out_valid", 32'(ov_s), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_sum", sum_s, 32'd0);
    check("midrst_in_ready", 32'(rdy_s), 32'd1);
    repeat (5) @(negedge clk);
    check("midrst_no_report", 32'(ov_s), 32'd0);
    send(16'd2, 16'd3, 17'd5);
    send(16'd7, 16'd8, 17'd15);
    wait_report();
    check("exact_sum", sum_s, 32'd0);
    check("exact_max", max_s, 32'd0);
    check("exact_cnt", cnt_s, 32'd0);
    check("exact_in_ready", 32'(rdy_s), 32'd0);
    handshake();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
